sync_delay_ctr: RTL
===================

Name: sync_delay_ctr

Overview:
- Counter-based delay for a single-cycle sync pulse.
- Runs beside bram_delay_behave in the xengine datapath so the frame sync stays aligned with data delayed by the same DELAY.
- Spends one down-counter on the 1-bit sync instead of a BRAM column.
- Flags syncs that arrive while a delay is in flight, which would otherwise lose frame alignment.

Parameters:
- DELAY, 128, delay in ce-qualified cycles; must equal the DELAY of the companion bram_delay_behave; legal range 0..2^CTR_WIDTH-1.
- CTR_WIDTH, 16, width of the internal down-counter.
- RETRIGGER, 0: 0 means ignore a sync that arrives while counting; 1 means restart the count on the new sync.
- MISS_WIDTH, 8, width of the saturating missed-sync counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ce  in  1  clock enable; state advances only on edges where ce=1.
- sync_in  in  1  sync pulse, sampled when ce=1.
- sync_out  out  1  delayed sync.
- busy  out  1  high while a delay is in flight.
- missed  out  MISS_WIDTH  count of dropped or overridden syncs, saturating.
- miss_pulse  out  1  one-clk strobe when a sync is dropped or overridden.

Behaviour:
- Reset: rst_n low asynchronously clears the following, regardless of ce: sync_out=0, busy=0, missed=0, miss_pulse=0, counter=0, state=IDLE. A reset during COUNT discards the pending pulse; no sync_out follows release.
- Alignment contract: the value of sync_out between ce-edges n and n+1 equals sync_in sampled at ce-edge n-DELAY+1. This is the same timing as dout versus din of bram_delay_behave at the same DELAY, with LATENCY folded in by the caller.
- DELAY=0: sync_out = sync_in combinationally; busy=0; missed stays 0; the counter is not built.
- DELAY=1: sync_out is a ce-enabled register of sync_in; busy is never asserted.
- DELAY>=2 uses a two-state FSM:
  - IDLE, sync_in=1 at a ce-edge: load cnt=DELAY-2, go to COUNT, busy=1.
  - COUNT, ce-edge, cnt!=0: cnt decrements.
  - COUNT, ce-edge, cnt=0: sync_out=1 at this edge; go to IDLE and clear busy, unless sync_in=1 on the same edge, in which case reload cnt=DELAY-2 and stay in COUNT. That new sync is not counted as missed.
  - sync_out is cleared at the next ce-edge, so it is high for exactly one ce-interval. It holds its value through ce=0 cycles.
- Sync arriving in COUNT with cnt!=0:
  - RETRIGGER=0: ignored; missed+1; miss_pulse=1.
  - RETRIGGER=1: reload cnt=DELAY-2; the old pending pulse is never emitted; missed+1; miss_pulse=1.
- missed saturates at all-ones and never wraps.
- miss_pulse is high for one clk cycle only; it is not ce-held.
- ce=0: the counter, state, sync_out and missed all hold; sync_in is ignored.
- Elaboration-time check: DELAY > 2^CTR_WIDTH-1 is an error ($error in a generate block).

Decomposition:
- No shared package needed: all widths are parameters.
- FSM state encoding is a localparam inside the module.
- Optional sub-module sat_counter (WIDTH parameter, inc/clear) for the missed counter. It can be reused by other general_lib error counters.

Test Plan:
- DELAY=128, ce=1, ctr-driven bench, sync_in pulse at cycle 10 -> sync_out high for exactly one cycle at cycle 137. This matches bram_delay_behave dout=10 at cycle 137 (LATENCY folded), checked with both blocks instantiated in parallel. busy is high for cycles 11..137.
- DELAY=128, ce toggling 1,0,1,0, sync at the 5th ce-edge -> sync_out asserted at the 132nd ce-edge and held across the following ce=0 cycle.
- RETRIGGER=0, syncs at cycles 10 and 50 -> single sync_out at 137; missed=1; miss_pulse at cycle 50.
- RETRIGGER=1, same stimulus -> single sync_out at 177; missed=1.
- Syncs every 128 cycles starting at cycle 10 -> sync_out at 137, 265, 393, ...; missed stays 0.
- rst_n low at cycle 60 after a sync at cycle 10 -> no sync_out afterwards; all outputs 0 immediately, without waiting for a clock edge.
- MISS_WIDTH=2 with 5 overlapping syncs -> missed=3, saturated.
- DELAY=0 -> sync_out equals sync_in in the same cycle.
- DELAY=1 -> sync_out lags sync_in by one cycle.

Source files
------------

// File: rtl/sync_delay_ctr_sat_counter.sv
// Saturating event counter: counts inc pulses up to all-ones and sticks there.
// Kept generic so other error counters in the library can reuse it.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/sync_delay_ctr.sv
// Delays a single-cycle frame sync by DELAY ce-qualified cycles using one down-counter,
// flagging syncs that arrive while a delay is still in flight.
//
// state   | meaning
// S_IDLE  | no sync pending, waiting for sync_in
// S_COUNT | sync pending, cnt counts down to the emit edge
module sync_delay_ctr #(
    parameter int DELAY      = 128,
    parameter int CTR_WIDTH  = 16,
    parameter int RETRIGGER  = 0,
    parameter int MISS_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ce,
    input  logic                  sync_in,
    output logic                  sync_out,
    output logic                  busy,
    output logic [MISS_WIDTH-1:0] missed,
    output logic                  miss_pulse
);

    generate
        if (longint'(DELAY) > ((64'd1 << CTR_WIDTH) - 64'd1)) begin : g_bad_delay
            $error("sync_delay_ctr: DELAY %0d does not fit in CTR_WIDTH %0d", DELAY, CTR_WIDTH);
        end

        if (DELAY == 0) begin : g_wire
            // Pure pass-through: clock, reset and enable play no part.
            logic unused_d0;
            assign unused_d0  = &{1'b0, clk, rst_n, ce};
            assign sync_out   = sync_in;
            assign busy       = 1'b0;
            assign missed     = '0;
            assign miss_pulse = 1'b0;
        end else if (DELAY == 1) begin : g_reg
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync_out <= 1'b0;
                end else if (ce) begin
                    sync_out <= sync_in;
                end
            end
            assign busy       = 1'b0;
            assign missed     = '0;
            assign miss_pulse = 1'b0;
        end else begin : g_fsm
            typedef enum logic {
                S_IDLE  = 1'b0,
                S_COUNT = 1'b1
            } state_t;

            // One edge is spent loading and one emitting, hence DELAY-2.
            localparam logic [CTR_WIDTH-1:0] LOAD = CTR_WIDTH'(DELAY - 2);

            state_t               state;
            logic [CTR_WIDTH-1:0] cnt;
            logic                 miss_hit;

            assign miss_hit = ce && sync_in && (state == S_COUNT) && (cnt != '0);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state      <= S_IDLE;
                    cnt        <= '0;
                    sync_out   <= 1'b0;
                    busy       <= 1'b0;
                    miss_pulse <= 1'b0;
                end else begin
                    miss_pulse <= miss_hit;
                    if (ce) begin
                        sync_out <= 1'b0;
                        case (state)
                            S_IDLE: begin
                                if (sync_in) begin
                                    cnt   <= LOAD;
                                    state <= S_COUNT;
                                    busy  <= 1'b1;
                                end
                            end
                            S_COUNT: begin
                                if (cnt == '0) begin
                                    sync_out <= 1'b1;
                                    // A sync landing on the emit edge starts a fresh delay.
                                    if (sync_in) begin
                                        cnt <= LOAD;
                                    end else begin
                                        state <= S_IDLE;
                                        busy  <= 1'b0;
                                    end
                                end else if (sync_in && (RETRIGGER != 0)) begin
                                    cnt <= LOAD;
                                end else begin
                                    cnt <= cnt - CTR_WIDTH'(1);
                                end
                            end
                            default: begin
                                state <= S_IDLE;
                                busy  <= 1'b0;
                            end
                        endcase
                    end
                end
            end

            sat_counter #(
                .WIDTH(MISS_WIDTH)
            ) u_miss_ctr (
                .clk  (clk),
                .rst_n(rst_n),
                .clear(1'b0),
                .inc  (miss_hit),
                .count(missed)
            );
        end
    endgenerate

endmodule
